// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: widths, bit placement and the encode function.
// Positions follow the decoder's 1-based syndrome convention (bit index = position - 1).
package hamming_pkg;

  localparam int HAMM_DATA_W = 4;
  localparam int HAMM_CW_W   = 7;

  localparam int POS_D0 = 2;
  localparam int POS_D1 = 4;
  localparam int POS_D2 = 5;
  localparam int POS_D3 = 6;

  localparam int POS_P1 = 0;
  localparam int POS_P2 = 1;
  localparam int POS_P4 = 3;

  typedef logic [HAMM_CW_W-1:0]   hamm_cw_t;
  typedef logic [HAMM_DATA_W-1:0] hamm_data_t;

  function automatic hamm_cw_t hamm_encode(input hamm_data_t nibble);
    hamm_cw_t cw;
    cw         = '0;
    cw[POS_D0] = nibble[0];
    cw[POS_D1] = nibble[1];
    cw[POS_D2] = nibble[2];
    cw[POS_D3] = nibble[3];
    cw[POS_P1] = nibble[0] ^ nibble[1] ^ nibble[3];
    cw[POS_P2] = nibble[0] ^ nibble[2] ^ nibble[3];
    cw[POS_P4] = nibble[1] ^ nibble[2] ^ nibble[3];
    return cw;
  endfunction

endpackage

// File: rtl/hamming_fifo2.sv
// Two-entry codeword FIFO; the head reads as zero whenever the FIFO is empty.
module hamming_fifo2
  import hamming_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  hamm_cw_t wr_data,
  output hamm_cw_t rd_data,
  output logic     full,
  output logic     empty
);

  hamm_cw_t   mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= !wr_ptr;
      if (do_pop)  rd_ptr <= !rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: stale entries are hidden by the empty gating above.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/hamming_encode_tx.sv
// Hamming(7,4) transmit stage: encode accepted nibbles, buffer in a 2-deep FIFO, count deliveries.
// Optional HAMM_ERR_INJECT_EN adds err_en/err_pos to flip one codeword bit at accept time.
module hamming_encode_tx
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       d_in,
`ifdef HAMM_ERR_INJECT_EN
  input  logic             err_en,
  input  logic [2:0]       err_pos,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       d_hamm,
  output logic [CNT_W-1:0] cw_count
);

  logic     rdy_en;
  logic     full;
  logic     empty;
  logic     push;
  logic     pop;
  hamm_cw_t wr_cw;

  // Keeps in_ready low through reset and until the first edge afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  assign in_ready  = rdy_en && !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_cw = hamm_encode(d_in);
`ifdef HAMM_ERR_INJECT_EN
    if (err_en && (err_pos != 3'd0)) wr_cw[err_pos - 3'd1] = ~wr_cw[err_pos - 3'd1];
`endif
  end

  hamming_fifo2 u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_cw),
    .rd_data (d_hamm),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cw_count <= '0;
    else if (pop) cw_count <= cw_count + 1'b1;
  end

endmodule
